uart_rx: RTL

//  UART receiver: the far-end consumer of the transmit datapath's serial_out. Oversamples

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: rx FSM state encoding, default sizing, 2-of-3 vote helper.
package uart_pkg;

  localparam int unsigned WordSizeDefault   = 8;
  localparam int unsigned OversampleDefault = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRecv,
    StStop,
    StBreak
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversample counter and bit decision sample for uart_rx.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of the last three ticks.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned Oversample = OversampleDefault,
  parameter int unsigned OsBits     = 4
) (
  input  logic clk,
  input  logic rst_b,
  input  logic i_serial_in,
  input  logic i_sample_tick,
  input  logic i_cnt_clr,
  output logic o_line,
  output logic o_sample,
  output logic o_at_mid,
  output logic o_at_end
);

  localparam logic [OsBits-1:0] Mid = OsBits'(Oversample / 2 - 1);
  localparam logic [OsBits-1:0] End = OsBits'(Oversample - 1);

  logic [1:0]        r_sync;
  logic [OsBits-1:0] r_count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_serial_in};
    end
  end

  assign o_line = r_sync[1];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_count <= '0;
    end else if (i_sample_tick) begin
      r_count <= i_cnt_clr ? '0 : r_count + 1'b1;
    end
  end

  assign o_at_mid = i_sample_tick && (r_count == Mid);
  assign o_at_end = i_sample_tick && (r_count == End);

`ifdef UART_RX_MAJORITY_EN
  // Line values seen at the two ticks preceding the current one (counts d-2, d-1).
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hist <= 2'b11;
    end else if (i_sample_tick) begin
      r_hist <= {r_hist[0], o_line};
    end
  end

  assign o_sample = maj3(r_hist[1], r_hist[0], o_line);
`else
  assign o_sample = o_line;
`endif

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: frame FSM, shift register and valid/ack handshake with sticky errors.
// Optional 2-of-3 bit voting via UART_RX_MAJORITY_EN (implemented in uart_rx_sampler).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WordSize     = WordSizeDefault,
  parameter int unsigned SizeBitCount = 3,
  parameter int unsigned Oversample   = OversampleDefault,
  parameter int unsigned OsBits       = 4
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                i_serial_in,
  input  logic                i_sample_tick,
  input  logic                i_read_ack,
  input  logic                i_clr_err,
  output logic [WordSize-1:0] o_rx_data,
  output logic                o_rx_valid,
  output logic                o_framing_error,
  output logic                o_overrun_error
);

  localparam logic [SizeBitCount:0] LastBit = (SizeBitCount + 1)'(WordSize - 1);

  rx_state_e             r_state, w_state_next;
  logic [WordSize-1:0]   r_shreg;
  logic [SizeBitCount:0] r_bit_count;

  logic w_line, w_sample, w_at_mid, w_at_end;
  logic w_cnt_clr, w_shift, w_deliver, w_set_fe, w_set_oe, w_accept;

  uart_rx_sampler #(
    .Oversample (Oversample),
    .OsBits     (OsBits)
  ) u_sampler (
    .clk           (clk),
    .rst_b         (rst_b),
    .i_serial_in   (i_serial_in),
    .i_sample_tick (i_sample_tick),
    .i_cnt_clr     (w_cnt_clr),
    .o_line        (w_line),
    .o_sample      (w_sample),
    .o_at_mid      (w_at_mid),
    .o_at_end      (w_at_end)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_shift      = 1'b0;
    w_deliver    = 1'b0;
    w_set_fe     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_clr = 1'b1;
        if (i_sample_tick && !w_line) w_state_next = StStart;
      end
      StStart: begin
        if (w_at_mid) begin
          w_cnt_clr    = 1'b1;
          w_state_next = w_sample ? StIdle : StRecv;
        end
      end
      StRecv: begin
        if (w_at_end) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_count == LastBit) w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_at_end) begin
          w_cnt_clr = 1'b1;
          if (w_sample) begin
            w_deliver    = 1'b1;
            w_state_next = StIdle;
          end else begin
            w_set_fe     = 1'b1;
            w_state_next = StBreak;
          end
        end
      end
      StBreak: begin
        // Wait for the line to return high so a held-low break is not seen as new starts.
        w_cnt_clr = 1'b1;
        if (i_sample_tick && w_line) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_accept = w_deliver && (!o_rx_valid || i_read_ack);
  assign w_set_oe = w_deliver && o_rx_valid && !i_read_ack;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= StIdle;
      r_shreg     <= '0;
      r_bit_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_shift) begin
        r_shreg     <= {w_sample, r_shreg[WordSize-1:1]};
        r_bit_count <= r_bit_count + 1'b1;
      end else if (r_state != StRecv) begin
        r_bit_count <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      o_rx_data       <= '0;
      o_rx_valid      <= 1'b0;
      o_framing_error <= 1'b0;
      o_overrun_error <= 1'b0;
    end else begin
      if (w_accept) begin
        o_rx_data  <= r_shreg;
        o_rx_valid <= 1'b1;
      end else if (i_read_ack) begin
        o_rx_valid <= 1'b0;
      end
      if (w_set_fe)       o_framing_error <= 1'b1;
      else if (i_clr_err) o_framing_error <= 1'b0;
      if (w_set_oe)       o_overrun_error <= 1'b1;
      else if (i_clr_err) o_overrun_error <= 1'b0;
    end
  end

endmodule
